dmem_responder: RTL and testbench

//  - Data-memory responder for the RV32I core: the memory end of the core's load/store port.
//  - Accepts one request at a time via valid/ready, applies byte lanes for SB/SH/SW, and returns LB/LH/LW/LBU/LHU data sign- or zero-extended.
//  - Holds DEPTH_WORDS x 32-bit storage with synchronous read and byte-enable write.
//  - Sits between the core's MEM stage and the register-file write-back mux.

---
 rtl/rv32_mem_pkg.sv | 37 +++
 rtl/dmem_lane_align.sv | 38 +++
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the RV32I data-memory responder: funct3 codes, FSM states,
// and request classification helpers used at accept time.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCESS   = 3'd1,
        SPLIT_LO = 3'd2,
        SPLIT_HI = 3'd3,
        RESP     = 3'd4
    } state_t;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 > F3_SW);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    // Access size lives in funct3[1:0] for both loads and stores.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] byte_off);
        case (f3[1:0])
            2'd1:    return byte_off[0];
            2'd2:    return (byte_off != 2'd0);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/data across a two-word window, load extraction + extension.
// Purely combinational, no latency, no flow control.
module dmem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    input  logic [63:0] rwin,
    output logic [7:0]  be,
    output logic [63:0] wdata_sh,
    output logic [31:0] rdata
);

    logic [7:0]  size_mask;
    logic [31:0] win_sh;

    always_comb begin
        case (funct3[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            default: size_mask = 8'h0F;
        endcase
        be       = size_mask << byte_off;
        wdata_sh = {32'h0, wdata} << {byte_off, 3'b000};
        // Bytes of the two-word window are little-endian, so a right shift aligns the load.
        win_sh   = 32'(rwin >> {byte_off, 3'b000});
        case (funct3)
            F3_LB:   rdata = {{24{win_sh[7]}}, win_sh[7:0]};
            F3_LH:   rdata = {{16{win_sh[15]}}, win_sh[15:0]};
            F3_LW:   rdata = win_sh;
            F3_LBU:  rdata = {24'h0, win_sh[7:0]};
            F3_LHU:  rdata = {16'h0, win_sh[15:0]};
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// RV32I data-memory responder; aligned/error latency 1, split (DMEM_MISALIGNED_SPLIT_EN) latency 2.
// One request in flight; req_ready only in IDLE, response held until rsp_ready.
module dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = ADDR_W - 2;

    logic [31:0] mem [DEPTH_WORDS];

    state_t            state;
    logic              lat_we;
    logic [2:0]        lat_f3;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              lat_err;
    logic [31:0]       rd_lo;
    logic [31:0]       rd_hi;

    logic accept;
    logic req_err;
    logic req_split;

    assign accept = req_valid && req_ready;

`ifdef DMEM_MISALIGNED_SPLIT_EN
    assign req_err   = f3_illegal(req_we, req_funct3);
    assign req_split = f3_misaligned(req_funct3, req_addr[1:0]) && !req_err;
`else
    assign req_err   = f3_illegal(req_we, req_funct3) || f3_misaligned(req_funct3, req_addr[1:0]);
    assign req_split = 1'b0;
`endif

    // In IDLE the aligner sees the live request (aligned stores write on the accept edge);
    // afterwards it sees the latched copy.
    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [31:0] al_wdata;
    logic [7:0]  al_be;
    logic [63:0] al_wdata_sh;
    logic [31:0] al_rdata;

    assign al_f3    = (state == IDLE) ? req_funct3    : lat_f3;
    assign al_off   = (state == IDLE) ? req_addr[1:0] : lat_addr[1:0];
    assign al_wdata = (state == IDLE) ? req_wdata     : lat_wdata;

    dmem_lane_align u_align (
        .funct3   (al_f3),
        .byte_off (al_off),
        .wdata    (al_wdata),
        .rwin     ({rd_hi, rd_lo}),
        .be       (al_be),
        .wdata_sh (al_wdata_sh),
        .rdata    (al_rdata)
    );

    logic [IDX_W-1:0] mem_idx;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wd;
    logic             mem_we;
    logic             rd_lo_en;
    logic             rd_hi_en;

    always_comb begin
        mem_idx  = req_addr[ADDR_W-1:2];
        mem_be   = al_be[3:0];
        mem_wd   = al_wdata_sh[31:0];
        mem_we   = 1'b0;
        rd_lo_en = 1'b0;
        rd_hi_en = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !req_split) begin
                    rd_lo_en = 1'b1;
                    mem_we   = req_we && !req_err;
                end
            end
            SPLIT_LO: begin
                mem_idx  = lat_addr[ADDR_W-1:2];
                rd_lo_en = 1'b1;
                mem_we   = lat_we;
            end
            SPLIT_HI: begin
                // Index arithmetic is IDX_W wide, so the last word wraps to word 0.
                mem_idx  = lat_addr[ADDR_W-1:2] + IDX_W'(1);
                mem_be   = al_be[7:4];
                mem_wd   = al_wdata_sh[63:32];
                rd_hi_en = 1'b1;
                mem_we   = lat_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b])
                        mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
                end
            end
            if (rd_lo_en)
                rd_lo <= mem[mem_idx];
            if (rd_hi_en)
                rd_hi <= mem[mem_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_f3    <= 3'd0;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            lat_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_f3    <= req_funct3;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_err   <= req_err;
                        req_ready <= 1'b0;
                        state     <= req_split ? SPLIT_LO : ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= lat_err;
                    state     <= RESP;
                end
                SPLIT_LO: begin
                    state <= SPLIT_HI;
                end
                SPLIT_HI: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Load data is derived from registered read words and latched fields, so it is stable in RESP.
    assign rsp_rdata = (rsp_valid && !rsp_err && !lat_we) ? al_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder; expectations depend on DMEM_MISALIGNED_SPLIT_EN.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(.DEPTH_WORDS(256), .ADDR_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   n_rsp = 0;
    logic prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented response cycle against the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            prev_vld = 1'b0;
        end else begin
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: got rdata %h err %b expected no response", rsp_rdata, rsp_err);
                end else begin
                    if (!prev_vld)
                        check($sformatf("rsp%0d_latency", n_rsp), 32'(cyc - last_acc), 32'(q[0].lat));
                    check($sformatf("rsp%0d_rdata", n_rsp), rsp_rdata, q[0].rdata);
                    check($sformatf("rsp%0d_err", n_rsp), {31'h0, rsp_err}, {31'h0, q[0].err});
                    check($sformatf("rsp%0d_req_ready_low", n_rsp), {31'h0, req_ready}, 32'h0);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        n_rsp++;
                    end
                end
            end
            prev_vld = rsp_valid && !rsp_ready;
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el);
        exp_t e;
        int   n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        e.rdata = er;
        e.err   = ee;
        e.lat   = el;
        q.push_back(e);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        last_acc  = cyc;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el);
        issue(we, f3, addr, wd, er, ee, el);
        drain();
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_req_ready", {31'h0, req_ready}, 32'h1);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", {31'h0, rsp_err}, 32'h0);

        // Aligned stores and loads with extension.
        run(1'b1, 3'd2, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        run(1'b0, 3'd2, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        run(1'b0, 3'd0, 10'h013, 32'h0, 32'hFFFFFFDE, 1'b0, 1);
        run(1'b0, 3'd4, 10'h013, 32'h0, 32'h000000DE, 1'b0, 1);
        run(1'b0, 3'd1, 10'h012, 32'h0, 32'hFFFFDEAD, 1'b0, 1);
        run(1'b0, 3'd5, 10'h010, 32'h0, 32'h0000BEEF, 1'b0, 1);
        run(1'b1, 3'd0, 10'h011, 32'hAAAAAA55, 32'h0, 1'b0, 1);
        run(1'b0, 3'd2, 10'h010, 32'h0, 32'hDEAD55EF, 1'b0, 1);
        run(1'b1, 3'd1, 10'h012, 32'hFFFF1234, 32'h0, 1'b0, 1);
        run(1'b0, 3'd2, 10'h010, 32'h0, 32'h123455EF, 1'b0, 1);
        run(1'b0, 3'd0, 10'h010, 32'h0, 32'hFFFFFFEF, 1'b0, 1);
        run(1'b0, 3'd1, 10'h010, 32'h0, 32'h000055EF, 1'b0, 1);
        run(1'b0, 3'd4, 10'h012, 32'h0, 32'h00000034, 1'b0, 1);

        // Illegal funct3: loads 3/6/7, stores >=3; no write.
        run(1'b0, 3'd3, 10'h010, 32'h0, 32'h0, 1'b1, 1);
        run(1'b0, 3'd6, 10'h010, 32'h0, 32'h0, 1'b1, 1);
        run(1'b0, 3'd7, 10'h010, 32'h0, 32'h0, 1'b1, 1);
        run(1'b1, 3'd3, 10'h010, 32'h00000000, 32'h0, 1'b1, 1);
        run(1'b1, 3'd4, 10'h010, 32'h00000000, 32'h0, 1'b1, 1);
        run(1'b0, 3'd2, 10'h010, 32'h0, 32'h123455EF, 1'b0, 1);

        // Hold: response stays stable while rsp_ready is low; a stray request is ignored.
        rsp_ready = 1'b0;
        issue(1'b0, 3'd2, 10'h010, 32'h0, 32'h123455EF, 1'b0, 1);
        req_we    = 1'b1;
        req_funct3 = 3'd2;
        req_addr  = 10'h010;
        req_wdata = 32'h0;
        req_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        run(1'b0, 3'd2, 10'h010, 32'h0, 32'h123455EF, 1'b0, 1);

        // Misaligned accesses.
        run(1'b1, 3'd2, 10'h010, 32'h44332211, 32'h0, 1'b0, 1);
        run(1'b1, 3'd2, 10'h014, 32'h88776655, 32'h0, 1'b0, 1);
        run(1'b1, 3'd2, 10'h3FC, 32'hCAFEF00D, 32'h0, 1'b0, 1);
        run(1'b1, 3'd2, 10'h000, 32'h600DD00D, 32'h0, 1'b0, 1);
`ifdef DMEM_MISALIGNED_SPLIT_EN
        run(1'b0, 3'd2, 10'h011, 32'h0, 32'h55443322, 1'b0, 2);
        run(1'b0, 3'd1, 10'h013, 32'h0, 32'h00005544, 1'b0, 2);
        run(1'b0, 3'd2, 10'h3FD, 32'h0, 32'h0DCAFEF0, 1'b0, 2);
        run(1'b1, 3'd2, 10'h013, 32'hA1B2C3D4, 32'h0, 1'b0, 2);
        run(1'b0, 3'd2, 10'h010, 32'h0, 32'hD4332211, 1'b0, 1);
        run(1'b0, 3'd2, 10'h014, 32'h0, 32'h88A1B2C3, 1'b0, 1);
        run(1'b1, 3'd1, 10'h3FF, 32'h0000BEEF, 32'h0, 1'b0, 2);
        run(1'b0, 3'd2, 10'h3FC, 32'h0, 32'hEFFEF00D, 1'b0, 1);
        run(1'b0, 3'd2, 10'h000, 32'h0, 32'h600DD0BE, 1'b0, 1);
        run(1'b0, 3'd3, 10'h011, 32'h0, 32'h0, 1'b1, 1);
`else
        run(1'b0, 3'd2, 10'h011, 32'h0, 32'h0, 1'b1, 1);
        run(1'b0, 3'd1, 10'h013, 32'h0, 32'h0, 1'b1, 1);
        run(1'b0, 3'd5, 10'h011, 32'h0, 32'h0, 1'b1, 1);
        run(1'b0, 3'd2, 10'h3FD, 32'h0, 32'h0, 1'b1, 1);
        run(1'b1, 3'd2, 10'h013, 32'hA1B2C3D4, 32'h0, 1'b1, 1);
        run(1'b1, 3'd1, 10'h011, 32'h0000FFFF, 32'h0, 1'b1, 1);
        run(1'b0, 3'd2, 10'h010, 32'h0, 32'h44332211, 1'b0, 1);
        run(1'b0, 3'd2, 10'h014, 32'h0, 32'h88776655, 1'b0, 1);
        run(1'b0, 3'd1, 10'h012, 32'h0, 32'h00004433, 1'b0, 1);
`endif

        // Reset mid-operation drops the pending response.
        run(1'b1, 3'd2, 10'h020, 32'h11111111, 32'h0, 1'b0, 1);
        run(1'b1, 3'd2, 10'h024, 32'h22222222, 32'h0, 1'b0, 1);
`ifdef DMEM_MISALIGNED_SPLIT_EN
        issue(1'b1, 3'd2, 10'h021, 32'hAABBCCDD, 32'h0, 1'b0, 2);
`else
        issue(1'b0, 3'd2, 10'h020, 32'h0, 32'h11111111, 1'b0, 1);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        check("midreset_req_ready", {31'h0, req_ready}, 32'h1);
        check("midreset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        reset = 1'b0;
`ifdef DMEM_MISALIGNED_SPLIT_EN
        run(1'b0, 3'd2, 10'h020, 32'h0, 32'hBBCCDD11, 1'b0, 1);
`else
        run(1'b0, 3'd2, 10'h020, 32'h0, 32'h11111111, 1'b0, 1);
`endif
        run(1'b0, 3'd2, 10'h024, 32'h0, 32'h22222222, 1'b0, 1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
